// File: rtl/fault_confinement_ctrl.sv
// -----------------------------------------------------------------------------
// fault_confinement_ctrl
//
// Fault-confinement controller for a CAN-style node. It watches error and
// success pulses from the transmit and receive paths, issues single-cycle
// command pulses to an external error-counter block, tracks the confinement
// state (ACTIVE / PASSIVE / BUS_OFF / RECOVER) from the counter values that
// block reports back, and runs the bus-off recovery sequence by counting bus
// idle occurrences (runs of IDLE_BITS recessive sample points).
//
// Build option:
//   FC_AUTO_RECOVERY_EN  defined   -> recovery is armed as soon as BUS_OFF is
//                                     entered; recover_req is ignored.
//                        undefined -> recovery is armed only by a recover_req
//                                     pulse while in BUS_OFF (default).
//
// Parameters:
//   IDLE_BITS             consecutive recessive bits forming one idle occurrence
//   RECOVERY_OCCURRENCES  idle occurrences required to leave BUS_OFF
//
// Ports:
//   clock             in   sole clock, rising edge
//   reset             in   asynchronous, active-high reset
//   enable            in   synchronous enable; low holds the block in reset state
//   bit_tick          in   one-cycle sample-point strobe
//   rx_bit            in   sampled bus level, 1 = recessive
//   tx_error          in   error pulse while transmitter
//   rx_error          in   error pulse while receiver
//   rx_error_primary  in   qualifies rx_error as primary (severe)
//   tx_success        in   transmit frame-success pulse
//   rx_success        in   receive frame-success pulse
//   recover_req       in   host request to start bus-off recovery
//   tec[8:0]          in   transmit error count from the counter block
//   rec[7:0]          in   receive error count from the counter block
//   tec_inc8          out  TEC += 8 command pulse
//   tec_dec           out  TEC -= 1 command pulse
//   rec_inc1          out  REC += 1 command pulse
//   rec_inc8          out  REC += 8 command pulse
//   rec_dec           out  REC -= 1 command pulse
//   counters_clear    out  one-cycle pulse zeroing both counters
//   state[1:0]        out  00 ACTIVE, 01 PASSIVE, 10 BUS_OFF, 11 RECOVER
//   error_active      out  state decode
//   error_passive     out  state decode
//   bus_off           out  state decode (RECOVER also decodes as bus_off)
//   tx_inhibit        out  high in BUS_OFF and RECOVER
//   recovery_count    out  idle occurrences seen in the current recovery
// -----------------------------------------------------------------------------
module fault_confinement_ctrl #(
    parameter int IDLE_BITS            = 11,
    parameter int RECOVERY_OCCURRENCES = 128
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic       bit_tick,
    input  logic       rx_bit,
    input  logic       tx_error,
    input  logic       rx_error,
    input  logic       rx_error_primary,
    input  logic       tx_success,
    input  logic       rx_success,
    input  logic       recover_req,
    input  logic [8:0] tec,
    input  logic [7:0] rec,
    output logic       tec_inc8,
    output logic       tec_dec,
    output logic       rec_inc1,
    output logic       rec_inc8,
    output logic       rec_dec,
    output logic       counters_clear,
    output logic [1:0] state,
    output logic       error_active,
    output logic       error_passive,
    output logic       bus_off,
    output logic       tx_inhibit,
    output logic [7:0] recovery_count
);

    localparam logic [1:0] ST_ACTIVE  = 2'b00;
    localparam logic [1:0] ST_PASSIVE = 2'b01;
    localparam logic [1:0] ST_BUS_OFF = 2'b10;
    localparam logic [1:0] ST_RECOVER = 2'b11;

    localparam int IDLE_W = $clog2(IDLE_BITS + 1);

    logic [1:0]        state_q;
    logic [1:0]        state_nxt;
    logic [IDLE_W-1:0] idle_cnt;
    logic              armed;
    logic              recovery_done;
    logic              cmd_allowed;
    logic              count_tick;

    // Counter commands are only meaningful while the node takes part in bus
    // traffic; BUS_OFF and RECOVER swallow every error/success pulse.
    assign cmd_allowed   = enable && ((state_q == ST_ACTIVE) || (state_q == ST_PASSIVE));
    assign recovery_done = (recovery_count >= 8'(RECOVERY_OCCURRENCES));

    // Idle bits are counted only while armed in BUS_OFF. The count freezes once
    // enough occurrences are collected so it cannot overshoot while the state
    // machine moves on to RECOVER.
    assign count_tick = (state_q == ST_BUS_OFF) && armed && bit_tick && !recovery_done;

`ifdef FC_AUTO_RECOVERY_EN
    // Recovery starts the moment BUS_OFF is entered; the host request has no
    // function in this build.
    logic unused_recover_req;
    assign unused_recover_req = recover_req;
    assign armed              = (state_q == ST_BUS_OFF);
`else
    logic armed_q;

    // The arm flag only survives inside BUS_OFF, so a request that arrives in
    // any other state (or before the node went bus-off) is discarded.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed_q <= 1'b0;
        end else if (!enable || (state_q != ST_BUS_OFF)) begin
            armed_q <= 1'b0;
        end else if (recover_req) begin
            armed_q <= 1'b1;
        end
    end

    assign armed = armed_q;
`endif

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_ACTIVE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state_q;
        if (!enable) begin
            state_nxt = ST_ACTIVE;
        end else begin
            case (state_q)
                ST_ACTIVE, ST_PASSIVE: begin
                    // Bus-off threshold is tested first so that a jump straight
                    // past 255 never lingers in PASSIVE.
                    if (tec >= 9'd256) begin
                        state_nxt = ST_BUS_OFF;
                    end else if ((tec >= 9'd128) || (rec >= 8'd128)) begin
                        state_nxt = ST_PASSIVE;
                    end else begin
                        state_nxt = ST_ACTIVE;
                    end
                end
                ST_BUS_OFF: begin
                    if (recovery_done) begin
                        state_nxt = ST_RECOVER;
                    end
                end
                ST_RECOVER: begin
                    state_nxt = ST_ACTIVE;
                end
                default: begin
                    state_nxt = ST_ACTIVE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Output decode
    // ---------------------------------------------------------------------
    always_comb begin
        error_active   = 1'b0;
        error_passive  = 1'b0;
        bus_off        = 1'b0;
        tx_inhibit     = 1'b0;
        counters_clear = 1'b0;
        case (state_q)
            ST_ACTIVE: begin
                error_active = 1'b1;
            end
            ST_PASSIVE: begin
                error_passive = 1'b1;
            end
            ST_BUS_OFF: begin
                bus_off    = 1'b1;
                tx_inhibit = 1'b1;
            end
            ST_RECOVER: begin
                // RECOVER lasts exactly one cycle, so the clear is a single
                // pulse. An asynchronous reset during recovery drops state_q to
                // ACTIVE and the pulse never appears.
                bus_off        = 1'b1;
                tx_inhibit     = 1'b1;
                counters_clear = 1'b1;
            end
            default: begin
                error_active = 1'b0;
            end
        endcase
    end

    assign state = state_q;

    // ---------------------------------------------------------------------
    // Recovery counters: idle-bit run length and idle occurrences
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idle_cnt       <= '0;
            recovery_count <= '0;
        end else if (!enable || (state_q == ST_RECOVER)) begin
            idle_cnt       <= '0;
            recovery_count <= '0;
        end else if (count_tick) begin
            if (!rx_bit) begin
                // A dominant bit breaks the run; a partial run is not credited.
                idle_cnt <= '0;
            end else if (idle_cnt == IDLE_W'(IDLE_BITS - 1)) begin
                // This tick completes an occurrence: credit it and start the
                // next run from zero in the same cycle.
                idle_cnt       <= '0;
                recovery_count <= recovery_count + 8'd1;
            end else begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------------
    // Registered counter commands (one cycle after the causing pulse)
    // ---------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tec_inc8 <= 1'b0;
            tec_dec  <= 1'b0;
            rec_inc1 <= 1'b0;
            rec_inc8 <= 1'b0;
            rec_dec  <= 1'b0;
        end else begin
            // On each counter an error in the same cycle as a success wins and
            // the success is dropped; the tx and rx paths do not interact.
            tec_inc8 <= cmd_allowed && tx_error;
            tec_dec  <= cmd_allowed && tx_success && !tx_error;
            rec_inc1 <= cmd_allowed && rx_error && !rx_error_primary;
            rec_inc8 <= cmd_allowed && rx_error && rx_error_primary;
            rec_dec  <= cmd_allowed && rx_success && !rx_error;
        end
    end

endmodule

// File: tb/tb_fault_confinement_ctrl.sv
module tb_fault_confinement_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       bit_tick;
    logic       rx_bit;
    logic       tx_error;
    logic       rx_error;
    logic       rx_error_primary;
    logic       tx_success;
    logic       rx_success;
    logic       recover_req;
    logic [8:0] tec;
    logic [7:0] rec;
    logic       tec_inc8;
    logic       tec_dec;
    logic       rec_inc1;
    logic       rec_inc8;
    logic       rec_dec;
    logic       counters_clear;
    logic [1:0] state;
    logic       error_active;
    logic       error_passive;
    logic       bus_off;
    logic       tx_inhibit;
    logic [7:0] recovery_count;

    int checks = 0;
    int errors = 0;

    // Expected command vector {tec_inc8, tec_dec, rec_inc1, rec_inc8, rec_dec}
    logic [4:0] exp_q[$];

    always #5 clock = ~clock;

    fault_confinement_ctrl #(
        .IDLE_BITS            (11),
        .RECOVERY_OCCURRENCES (128)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .enable           (enable),
        .bit_tick         (bit_tick),
        .rx_bit           (rx_bit),
        .tx_error         (tx_error),
        .rx_error         (rx_error),
        .rx_error_primary (rx_error_primary),
        .tx_success       (tx_success),
        .rx_success       (rx_success),
        .recover_req      (recover_req),
        .tec              (tec),
        .rec              (rec),
        .tec_inc8         (tec_inc8),
        .tec_dec          (tec_dec),
        .rec_inc1         (rec_inc1),
        .rec_inc8         (rec_inc8),
        .rec_dec          (rec_dec),
        .counters_clear   (counters_clear),
        .state            (state),
        .error_active     (error_active),
        .error_passive    (error_passive),
        .bus_off          (bus_off),
        .tx_inhibit       (tx_inhibit),
        .recovery_count   (recovery_count)
    );

    function automatic logic [4:0] cmd_vec();
        return {tec_inc8, tec_dec, rec_inc1, rec_inc8, rec_dec};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Drive one set of error/success pulses and queue the command vector the
    // node must answer with one cycle later.
    task automatic apply_cmd(input logic [4:0] pat, input logic allowed);
        logic [4:0] e;
        tx_error         = pat[4];
        tx_success       = pat[3];
        rx_error         = pat[2];
        rx_error_primary = pat[1];
        rx_success       = pat[0];
        e[4] = pat[4];
        e[3] = pat[3] & ~pat[4];
        e[2] = pat[2] & ~pat[1];
        e[1] = pat[2] & pat[1];
        e[0] = pat[0] & ~pat[2];
        exp_q.push_back(allowed ? e : 5'b00000);
    endtask

    task automatic clear_cmd();
        tx_error         = 1'b0;
        tx_success       = 1'b0;
        rx_error         = 1'b0;
        rx_error_primary = 1'b0;
        rx_success       = 1'b0;
    endtask

    task automatic send_ticks(input int n, input logic level);
        rx_bit   = level;
        bit_tick = 1'b1;
        repeat (n) step();
        bit_tick = 1'b0;
        rx_bit   = 1'b1;
    endtask

    task automatic test_reset();
        enable      = 1'b1;
        bit_tick    = 1'b0;
        rx_bit      = 1'b1;
        recover_req = 1'b0;
        tec         = '0;
        rec         = '0;
        clear_cmd();
        reset = 1'b1;
        step();
        step();
        checks++;
        if (state !== 2'b00) begin
            errors++; $display("FAIL reset_state: got %b expected 00", state);
        end
        checks++;
        if ({error_active, error_passive, bus_off, tx_inhibit, counters_clear} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_status: got %b expected 10000",
                     {error_active, error_passive, bus_off, tx_inhibit, counters_clear});
        end
        checks++;
        if (cmd_vec() !== 5'b00000 || recovery_count !== 8'd0) begin
            errors++; $display("FAIL reset_cmds: got cmd %b rc %0d expected 00000 rc 0", cmd_vec(), recovery_count);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_commands();
        logic [4:0] pats [9];
        logic [4:0] e;
        pats = '{5'b10000, 5'b01000, 5'b00100, 5'b00110, 5'b00111,
                 5'b11000, 5'b00001, 5'b10001, 5'b01100};
        foreach (pats[i]) begin
            apply_cmd(pats[i], 1'b1);
            checks++;
            if (cmd_vec() !== 5'b00000) begin
                errors++; $display("FAIL cmd_early[%0d]: got %b expected 00000", i, cmd_vec());
            end
            step();
            clear_cmd();
            e = exp_q.pop_front();
            checks++;
            if (cmd_vec() !== e) begin
                errors++; $display("FAIL cmd_pulse[%0d]: got %b expected %b", i, cmd_vec(), e);
            end
            step();
            checks++;
            if (cmd_vec() !== 5'b00000 || state !== 2'b00) begin
                errors++; $display("FAIL cmd_width[%0d]: got cmd %b state %b expected 00000 00", i, cmd_vec(), state);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] e;
        for (int i = 0; i < 3; i++) begin
            apply_cmd(5'b10000, 1'b1);
            step();
            e = exp_q.pop_front();
            checks++;
            if (cmd_vec() !== e) begin
                errors++; $display("FAIL b2b[%0d]: got %b expected %b", i, cmd_vec(), e);
            end
        end
        clear_cmd();
        step();
    endtask

    task automatic test_passive();
        logic [4:0] e;
        rec = 8'd127;
        step();
        checks++;
        if (state !== 2'b00 || error_active !== 1'b1) begin
            errors++; $display("FAIL rec127: got state %b ea %b expected 00 1", state, error_active);
        end
        rec = 8'd128;
        step();
        checks++;
        if (state !== 2'b01 || error_passive !== 1'b1 || error_active !== 1'b0) begin
            errors++; $display("FAIL rec128: got state %b ep %b ea %b expected 01 1 0", state, error_passive, error_active);
        end
        apply_cmd(5'b10110, 1'b1);
        step();
        clear_cmd();
        e = exp_q.pop_front();
        checks++;
        if (cmd_vec() !== e) begin
            errors++; $display("FAIL passive_cmd: got %b expected %b", cmd_vec(), e);
        end
        rec = 8'd127;
        step();
        checks++;
        if (state !== 2'b00 || error_passive !== 1'b0) begin
            errors++; $display("FAIL rec127_back: got state %b ep %b expected 00 0", state, error_passive);
        end
        tec = 9'd128;
        step();
        checks++;
        if (state !== 2'b01) begin
            errors++; $display("FAIL tec128: got %b expected 01", state);
        end
        tec = 9'd0;
        rec = 8'd0;
        step();
        checks++;
        if (state !== 2'b00) begin
            errors++; $display("FAIL tec_back: got %b expected 00", state);
        end
    endtask

    task automatic test_bus_off_recovery();
        logic [4:0] e;
`ifndef FC_AUTO_RECOVERY_EN
        // A request outside BUS_OFF must not pre-arm recovery.
        recover_req = 1'b1;
        step();
        recover_req = 1'b0;
`endif
        rec = 8'd200;
        step();
        checks++;
        if (state !== 2'b01) begin
            errors++; $display("FAIL pre_busoff: got %b expected 01", state);
        end
        tec = 9'd300;
        step();
        checks++;
        if (state !== 2'b10 || tx_inhibit !== 1'b1 || bus_off !== 1'b1 || error_passive !== 1'b0) begin
            errors++; $display("FAIL busoff_entry: got state %b ti %b bo %b ep %b expected 10 1 1 0",
                               state, tx_inhibit, bus_off, error_passive);
        end
        apply_cmd(5'b11111, 1'b0);
        step();
        clear_cmd();
        e = exp_q.pop_front();
        checks++;
        if (cmd_vec() !== e) begin
            errors++; $display("FAIL busoff_suppress: got %b expected %b", cmd_vec(), e);
        end
`ifndef FC_AUTO_RECOVERY_EN
        send_ticks(1408, 1'b1);
        checks++;
        if (recovery_count !== 8'd0 || state !== 2'b10) begin
            errors++; $display("FAIL unarmed_ticks: got rc %0d state %b expected 0 10", recovery_count, state);
        end
        recover_req = 1'b1;
        step();
        recover_req = 1'b0;
`endif
        send_ticks(10, 1'b1);
        send_ticks(1, 1'b0);
        send_ticks(11, 1'b1);
        checks++;
        if (recovery_count !== 8'd1) begin
            errors++; $display("FAIL broken_run: got rc %0d expected 1", recovery_count);
        end
        send_ticks(127 * 11, 1'b1);
        checks++;
        if (recovery_count !== 8'd128 || state !== 2'b10) begin
            errors++; $display("FAIL occ_done: got rc %0d state %b expected 128 10", recovery_count, state);
        end
        step();
        checks++;
        if (state !== 2'b11 || counters_clear !== 1'b1 || bus_off !== 1'b1 || tx_inhibit !== 1'b1) begin
            errors++; $display("FAIL recover: got state %b cc %b bo %b ti %b expected 11 1 1 1",
                               state, counters_clear, bus_off, tx_inhibit);
        end
        tec = 9'd0;
        rec = 8'd0;
        step();
        checks++;
        if (state !== 2'b00 || counters_clear !== 1'b0 || recovery_count !== 8'd0 || error_active !== 1'b1) begin
            errors++; $display("FAIL post_recover: got state %b cc %b rc %0d ea %b expected 00 0 0 1",
                               state, counters_clear, recovery_count, error_active);
        end
    endtask

    task automatic test_reset_mid_recovery();
        logic [7:0] exp_rc;
        tec = 9'd256;
        step();
`ifndef FC_AUTO_RECOVERY_EN
        recover_req = 1'b1;
        step();
        recover_req = 1'b0;
`endif
        send_ticks(25, 1'b1);
        checks++;
        if (recovery_count !== 8'd2) begin
            errors++; $display("FAIL mid_count: got %0d expected 2", recovery_count);
        end
        tec = 9'd0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 2'b00 || recovery_count !== 8'd0 || counters_clear !== 1'b0) begin
            errors++; $display("FAIL async_reset: got state %b rc %0d cc %b expected 00 0 0",
                               state, recovery_count, counters_clear);
        end
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (counters_clear !== 1'b0 || state !== 2'b00) begin
                errors++; $display("FAIL no_clear[%0d]: got cc %b state %b expected 0 00", i, counters_clear, state);
            end
        end
        // Re-enter BUS_OFF without a new request: the old arm must be gone.
        tec = 9'd256;
        step();
        send_ticks(11, 1'b1);
`ifdef FC_AUTO_RECOVERY_EN
        exp_rc = 8'd1;
`else
        exp_rc = 8'd0;
`endif
        checks++;
        if (recovery_count !== exp_rc) begin
            errors++; $display("FAIL rearm: got %0d expected %0d", recovery_count, exp_rc);
        end
    endtask

    task automatic test_enable();
        logic [4:0] e;
        send_ticks(11, 1'b1);
        enable = 1'b0;
        apply_cmd(5'b10110, 1'b0);
        step();
        clear_cmd();
        e = exp_q.pop_front();
        checks++;
        if (state !== 2'b00 || recovery_count !== 8'd0 || cmd_vec() !== e) begin
            errors++; $display("FAIL enable_low: got state %b rc %0d cmd %b expected 00 0 %b",
                               state, recovery_count, cmd_vec(), e);
        end
        tec = 9'd0;
        rec = 8'd200;
        step();
        checks++;
        if (state !== 2'b00) begin
            errors++; $display("FAIL enable_hold: got %b expected 00", state);
        end
        enable = 1'b1;
        step();
        checks++;
        if (state !== 2'b01) begin
            errors++; $display("FAIL enable_resume: got %b expected 01", state);
        end
        rec = 8'd0;
        step();
    endtask

    initial begin
        test_reset();
        test_commands();
        test_back_to_back();
        test_passive();
        test_bus_off_recovery();
        test_reset_mid_recovery();
        test_enable();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fault_confinement_ctrl.md
FAULT_CONFINEMENT_CTRL -- requirements
Module: fault_confinement_ctrl

Interface
REQ-001 SHALL have parameter IDLE_BITS, default 11: consecutive recessive bits forming one bus-idle occurrence.
REQ-002 SHALL have parameter RECOVERY_OCCURRENCES, default 128: idle occurrences required to leave bus-off.
REQ-003 clock  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  synchronous enable; low holds the block in reset state.
REQ-006 bit_tick  in  1  one-cycle sample-point strobe.
REQ-007 rx_bit  in  1  sampled bus level, 1 = recessive.
REQ-008 tx_error / rx_error  in  1 each  one-cycle error pulses while transmitter / receiver.
REQ-009 rx_error_primary  in  1  qualifies rx_error as primary (severe).
REQ-010 tx_success / rx_success  in  1 each  one-cycle frame-success pulses.
REQ-011 recover_req  in  1  host request to start bus-off recovery.
REQ-012 tec  in  9  transmit error count from the counter block; rec  in  8  receive error count.
REQ-013 tec_inc8, tec_dec, rec_inc1, rec_inc8, rec_dec  out  1 each  one-cycle counter command pulses.
REQ-014 counters_clear  out  1  one-cycle pulse zeroing both counters.
REQ-015 state  out  2  00 ACTIVE, 01 PASSIVE, 10 BUS_OFF, 11 RECOVER.
REQ-016 error_active, error_passive, bus_off, tx_inhibit  out  1 each  decoded status; recovery_count  out  8  idle occurrences seen.

Function
REQ-017 Command pulses SHALL be registered: asserted exactly one cycle after the causing input pulse, width one cycle.
REQ-018 tx_error SHALL produce tec_inc8; rx_error SHALL produce rec_inc8 if rx_error_primary else rec_inc1.
REQ-019 tx_success SHALL produce tec_dec; rx_success SHALL produce rec_dec.
REQ-020 Same-cycle error and success on the same counter: error command only, success dropped; tx and rx paths SHALL be independent.
REQ-021 No counter commands SHALL issue in BUS_OFF or RECOVER.
REQ-022 ACTIVE -> PASSIVE when tec >= 128 or rec >= 128; PASSIVE -> ACTIVE when tec < 128 and rec < 128.
REQ-023 ACTIVE or PASSIVE -> BUS_OFF when tec >= 256; this check SHALL take priority over REQ-022.
REQ-024 In BUS_OFF with recovery armed, each bit_tick with rx_bit=1 SHALL increment an idle-bit counter; rx_bit=0 SHALL clear it.
REQ-025 Idle-bit counter reaching IDLE_BITS SHALL increment recovery_count and restart at 0 in the same cycle.
REQ-026 recovery_count reaching RECOVERY_OCCURRENCES SHALL move BUS_OFF -> RECOVER.
REQ-027 RECOVER SHALL assert counters_clear for exactly one cycle, then go to ACTIVE and zero recovery_count and the idle-bit counter.
REQ-028 Outputs error_active/error_passive/bus_off SHALL be one-hot decodes of state (RECOVER decodes as bus_off); tx_inhibit = 1 in BUS_OFF and RECOVER.
REQ-029 enable low SHALL force state ACTIVE, zero all internal counters and suppress all pulses on the next edge.

Reset
REQ-030 On reset: state = ACTIVE, error_active = 1, all other outputs 0, recovery_count = 0, idle-bit counter = 0, recovery not armed.
REQ-031 reset asserted mid-recovery SHALL abandon the sequence; no counters_clear pulse SHALL be emitted.

Configuration
REQ-032 Macro FC_AUTO_RECOVERY_EN defined: recovery is armed immediately on entering BUS_OFF; recover_req is ignored.
REQ-033 FC_AUTO_RECOVERY_EN undefined: recovery arms only on a recover_req pulse while in BUS_OFF; bit_ticks before arming SHALL NOT count; recover_req outside BUS_OFF is ignored.

Verification
REQ-034 tx_error pulse, tec=0 -> tec_inc8 high one cycle later for one cycle; state stays 00.
REQ-035 rx_error with rx_error_primary=1 and rx_success in same cycle -> rec_inc8 only, no rec_dec.
REQ-036 rec driven 127 -> 128 -> 127 -> state 00 -> 01 -> 00, error_passive tracks.
REQ-037 tec=256 -> BUS_OFF, tx_inhibit=1; 128 x 11 recessive ticks (auto mode) -> RECOVER, counters_clear one cycle, then state 00.
REQ-038 In BUS_OFF, 10 recessive, 1 dominant, 11 recessive ticks -> recovery_count = 1, not 2.
REQ-039 Macro undefined: 1408 recessive ticks before recover_req -> recovery_count stays 0; after recover_req, count proceeds per REQ-037.
